sha2_msg_schedule: RTL and testbench
====================================

# sha2_msg_schedule

Parametrised SHA-2 message-schedule engine that accepts one 16-word message block and streams out the expanded schedule words W_0 … W_(ROUNDS-1), one per handshake, to the compression round datapath. It generalises the SHA-256 schedule sigma functions to both the SHA-224/256 (32-bit word) and SHA-384/512 (64-bit word) families. It uses a 16-entry sliding window, so the design stores no full 64/80-word array. It has ready/valid handshakes on input and output, so a multi-cycle compression core can backpressure it.

## Interface
Parameters:
- WORD_W, 32 — word width; legal values are 32 (SHA-224/256) and 64 (SHA-384/512); any other value is a synthesis-time error.
- ROUNDS, 64 — number of schedule words emitted; 64 for WORD_W=32, 80 for WORD_W=64.

Ports:
- clk  in  1  — single clock; all state changes on rising edge.
- rst  in  1  — synchronous, active-high reset.
- start  in  1  — begin a new block; honoured only in IDLE.
- abort  in  1  — synchronous return to IDLE from any state; the window contents are left stale.
- load_valid  in  1  — load_data is valid.
- load_ready  out  1  — high only in LOAD.
- load_data  in  WORD_W  — message word, in order M_0 first.
- w_valid  out  1  — w_data and w_index are valid; high only in RUN.
- w_ready  in  1  — consumer accepts the current word.
- w_data  out  WORD_W  — schedule word W_t.
- w_index  out  7  — t, from 0 to ROUNDS-1.
- done  out  1  — one-cycle pulse after W_(ROUNDS-1) is accepted.
- busy  out  1  — high whenever the state is not IDLE.

## Operation
- Window: r[0..15], each WORD_W bits; r[0] is the oldest entry. w_data = r[0] (a register output, with no combinational path from any input).
- LOAD shift, on load_valid && load_ready: r[i] <= r[i+1] for i = 0..14; r[15] <= load_data. The counter cnt increments.
- RUN shift, on w_valid && w_ready: r[i] <= r[i+1]; r[15] <= σ1(r[14]) + r[9] + σ0(r[1]) + r[0], mod 2^WORD_W. At the moment W_t is presented, r[k] = W_(t+k), so a single rule covers all t, including t < 16.
- Sigma functions for WORD_W=32:
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1 = ROTR17 ^ ROTR19 ^ SHR10.
- Sigma functions for WORD_W=64:
  - σ0 = ROTR1 ^ ROTR8 ^ SHR7.
  - σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- Adder: the four-input addition uses a carry-save or adder-tree structure and must close timing in a single cycle.
- FSM states and transitions:
  - IDLE: start → LOAD, with cnt <= 0.
  - LOAD: after the 16th accepted word → RUN, with cnt <= 0.
  - RUN: the accept with cnt == ROUNDS-1 → DONE.
  - DONE: unconditionally → IDLE after one cycle. done = 1 only in DONE.
- w_index = cnt during RUN.
- Boundary and priority rules:
  - start outside IDLE is ignored, as is start coinciding with abort.
  - Priority order is rst > abort > handshake.
  - Under backpressure (w_ready=0), w_data, w_index and the window hold unchanged.
  - load_valid outside LOAD is ignored.
  - An abort or rst in the middle of LOAD or RUN discards the block; the next start must reload all 16 words.

## Timing
- Reset values: state = IDLE, cnt = 0, r[*] = 0. Resulting outputs: load_ready = 0, w_valid = 0, w_data = 0, w_index = 0, done = 0, busy = 0.
- start at edge N puts the block in LOAD at N+1 (load_ready = 1).
- At full throughput the block accepts one load word per cycle, so 16 cycles for LOAD.
- W_0 is valid in the cycle after the 16th load accept. The throughput is one W per cycle while w_ready = 1.
- Total time for a block is 1 + 16 + ROUNDS + 1 cycles, i.e. 82 for SHA-256 and 98 for SHA-512. The last term is the DONE cycle.
- The next start is accepted no earlier than the cycle after DONE.

## Structure
- A shared package sha2_pkg holds:
  - the rotation/shift constants per WORD_W;
  - the ROUNDS defaults;
  - the FSM state encoding: IDLE, LOAD, RUN, DONE.
- One sub-module is natural: sha2_sched_sigma. It takes parameter WORD_W, input x, and outputs s0 and s1, and selects the rotation set at elaboration time.
- The FSM, counter, window and adder live in the top module.

## Test plan
- SHA-256 "abc" block (M_0 = 0x61626380, M_1..M_14 = 0, M_15 = 0x00000018) with w_ready tied high:
  - W_0..W_15 echo the input.
  - W_16 = 0x61626380 and W_17 = 0x000F0000.
  - W_18..W_63 match the software model.
  - done fires exactly 82 cycles after start.
- WORD_W = 64, ROUNDS = 80, with SHA-512 "abc" (M_0 = 0x6162638000000000, M_15 = 0x18):
  - W_16 = 0x6162638000000000 and W_17 = 0x00030000000000C0.
  - All 80 words match the model.
  - w_index ends at 79.
- Random w_ready and load_valid toggling:
  - w_data and w_index are stable whenever w_valid && !w_ready.
  - The output sequence is identical to the no-stall run.
- abort asserted at t = 30 of RUN:
  - The block is in IDLE next cycle with no done pulse.
  - A following start plus a fresh block yields correct words.
- rst asserted in the middle of LOAD (after 7 words):
  - All outputs are at their reset values next cycle.
- start pulsed during RUN and during DONE:
  - Both are ignored; the sequence and index are unaffected.
  - Exactly one done pulse occurs per block.

Source files
------------

// File: rtl/sha2_pkg.sv
// ---------------------------------------------------------------------------
// sha2_pkg
// Shared definitions for the SHA-2 message-schedule engine:
//   - word widths and default round counts for the SHA-256 and SHA-512 families
//   - rotation/shift amounts of the schedule sigma functions per word width
//   - sliding-window depth and schedule index width
//   - FSM state encoding of the schedule engine
// ---------------------------------------------------------------------------
package sha2_pkg;

  localparam int SHA256_WORD_W = 32;
  localparam int SHA512_WORD_W = 64;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_ROUNDS = 80;

  localparam int WINDOW_DEPTH  = 16;
  localparam int INDEX_W       = 7;

  // Small sigma amounts, 32-bit family: s0 = ROTR7 ^ ROTR18 ^ SHR3, s1 = ROTR17 ^ ROTR19 ^ SHR10
  localparam int S0_ROT_A_32 = 7;
  localparam int S0_ROT_B_32 = 18;
  localparam int S0_SHR_32   = 3;
  localparam int S1_ROT_A_32 = 17;
  localparam int S1_ROT_B_32 = 19;
  localparam int S1_SHR_32   = 10;

  // Small sigma amounts, 64-bit family: s0 = ROTR1 ^ ROTR8 ^ SHR7, s1 = ROTR19 ^ ROTR61 ^ SHR6
  localparam int S0_ROT_A_64 = 1;
  localparam int S0_ROT_B_64 = 8;
  localparam int S0_SHR_64   = 7;
  localparam int S1_ROT_A_64 = 19;
  localparam int S1_ROT_B_64 = 61;
  localparam int S1_SHR_64   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_e;

  // Default round count that matches a given word width.
  function automatic int default_rounds(input int word_w);
    return (word_w == SHA512_WORD_W) ? SHA512_ROUNDS : SHA256_ROUNDS;
  endfunction

endpackage

// File: rtl/sha2_sched_sigma.sv
// ---------------------------------------------------------------------------
// sha2_sched_sigma
// Message-schedule small sigma functions for one input word. The rotation
// set (SHA-256 or SHA-512 family) is chosen at elaboration time from WORD_W.
// Ports:
//   x   in  WORD_W  operand
//   s0  out WORD_W  sigma0(x)
//   s1  out WORD_W  sigma1(x)
// Purely combinational.
// ---------------------------------------------------------------------------
module sha2_sched_sigma
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  localparam bit IS_64 = (WORD_W == SHA512_WORD_W);

  localparam int S0_A = IS_64 ? S0_ROT_A_64 : S0_ROT_A_32;
  localparam int S0_B = IS_64 ? S0_ROT_B_64 : S0_ROT_B_32;
  localparam int S0_S = IS_64 ? S0_SHR_64   : S0_SHR_32;
  localparam int S1_A = IS_64 ? S1_ROT_A_64 : S1_ROT_A_32;
  localparam int S1_B = IS_64 ? S1_ROT_B_64 : S1_ROT_B_32;
  localparam int S1_S = IS_64 ? S1_SHR_64   : S1_SHR_32;

  generate
    if ((WORD_W != SHA256_WORD_W) && (WORD_W != SHA512_WORD_W)) begin : g_bad_word_w
      $error("sha2_sched_sigma: WORD_W must be 32 or 64");
    end
  endgenerate

  // Rotate right by a constant amount; amounts are always 1..WORD_W-1.
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  assign s0 = rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_S);
  assign s1 = rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_S);

endmodule

// File: rtl/sha2_msg_schedule.sv
// ---------------------------------------------------------------------------
// sha2_msg_schedule
// SHA-2 message-schedule engine. Accepts a 16-word block through a
// ready/valid load port, then streams W_0 .. W_(ROUNDS-1) through a
// ready/valid output port using a 16-entry sliding window.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begin a new block (only honoured in IDLE)
//   abort              return to IDLE from any state
//   load_valid/ready   load handshake, load_data = M_0 first
//   w_valid/ready      schedule-word handshake
//   w_data, w_index    schedule word W_t and its index t
//   done               one-cycle pulse after the last word is accepted
//   busy               high whenever not IDLE
// ---------------------------------------------------------------------------
module sha2_msg_schedule
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [WORD_W-1:0]   load_data,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [WORD_W-1:0]   w_data,
  output logic [INDEX_W-1:0]  w_index,
  output logic                done,
  output logic                busy
);

  generate
    if ((ROUNDS <= WINDOW_DEPTH) || (ROUNDS > (1 << INDEX_W))) begin : g_bad_rounds
      $error("sha2_msg_schedule: ROUNDS out of range");
    end
  endgenerate

  localparam logic [INDEX_W-1:0] LAST_LOAD  = INDEX_W'(WINDOW_DEPTH - 1);
  localparam logic [INDEX_W-1:0] LAST_ROUND = INDEX_W'(ROUNDS - 1);

  sched_state_e        state_r;
  sched_state_e        state_next_s;
  logic [INDEX_W-1:0]  cnt_r;
  logic [INDEX_W-1:0]  cnt_next_s;
  logic [WORD_W-1:0]   win_r [WINDOW_DEPTH];

  logic                load_ready_r;
  logic                w_valid_r;
  logic                done_r;
  logic                busy_r;

  logic                load_fire_s;
  logic                run_fire_s;
  logic                shift_s;
  logic [WORD_W-1:0]   shift_in_s;

  logic [WORD_W-1:0]   s0_r1_s;
  logic [WORD_W-1:0]   s1_r14_s;
  logic [WORD_W-1:0]   s1_unused_r1_s;
  logic [WORD_W-1:0]   s0_unused_r14_s;
  logic [WORD_W-1:0]   sum_hi_s;
  logic [WORD_W-1:0]   sum_lo_s;
  logic [WORD_W-1:0]   new_word_s;

  // sigma0 is only needed on r[1] and sigma1 only on r[14]; the other outputs are dropped.
  sha2_sched_sigma #(.WORD_W(WORD_W)) u_sigma_r1 (
    .x  (win_r[1]),
    .s0 (s0_r1_s),
    .s1 (s1_unused_r1_s)
  );

  sha2_sched_sigma #(.WORD_W(WORD_W)) u_sigma_r14 (
    .x  (win_r[14]),
    .s0 (s0_unused_r14_s),
    .s1 (s1_r14_s)
  );

  // Two-level adder tree: W_(t+16) = s1(W_(t+14)) + W_(t+9) + s0(W_(t+1)) + W_t.
  always_comb begin
    sum_hi_s   = s1_r14_s + win_r[9];
    sum_lo_s   = s0_r1_s + win_r[0];
    new_word_s = sum_hi_s + sum_lo_s;
  end

  // Handshake decode; abort suppresses any window update in the same cycle.
  always_comb begin
    load_fire_s = load_valid & load_ready_r;
    run_fire_s  = w_valid_r & w_ready;
    if (abort) begin
      shift_s = 1'b0;
    end else begin
      shift_s = load_fire_s | run_fire_s;
    end
    if (load_fire_s) begin
      shift_in_s = load_data;
    end else begin
      shift_in_s = new_word_s;
    end
  end

  // Next-state and counter logic; abort wins over every handshake.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (abort) begin
      state_next_s = ST_IDLE;
      cnt_next_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_next_s = ST_LOAD;
            cnt_next_s   = '0;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (load_fire_s) begin
            if (cnt_r == LAST_LOAD) begin
              state_next_s = ST_RUN;
              cnt_next_s   = '0;
            end else begin
              cnt_next_s   = cnt_r + 7'd1;
            end
          end else begin
            cnt_next_s = cnt_r;
          end
        end
        ST_RUN: begin
          if (run_fire_s) begin
            if (cnt_r == LAST_ROUND) begin
              // Index holds at ROUNDS-1 so the final value stays visible.
              state_next_s = ST_DONE;
            end else begin
              cnt_next_s   = cnt_r + 7'd1;
            end
          end else begin
            cnt_next_s = cnt_r;
          end
        end
        ST_DONE: begin
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
          cnt_next_s   = '0;
        end
      endcase
    end
  end

  // State, counter and status flags; flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      load_ready_r <= 1'b0;
      w_valid_r    <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      load_ready_r <= (state_next_s == ST_LOAD);
      w_valid_r    <= (state_next_s == ST_RUN);
      done_r       <= (state_next_s == ST_DONE);
      busy_r       <= (state_next_s != ST_IDLE);
    end
  end

  // Sliding window: r[0] is the oldest word and drives w_data directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WINDOW_DEPTH; i++) begin
        win_r[i] <= '0;
      end
    end else if (shift_s) begin
      for (int i = 0; i < WINDOW_DEPTH - 1; i++) begin
        win_r[i] <= win_r[i+1];
      end
      win_r[WINDOW_DEPTH-1] <= shift_in_s;
    end else begin
      for (int i = 0; i < WINDOW_DEPTH; i++) begin
        win_r[i] <= win_r[i];
      end
    end
  end

  assign load_ready = load_ready_r;
  assign w_valid    = w_valid_r;
  assign w_data     = win_r[0];
  assign w_index    = cnt_r;
  assign done       = done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// ---------------------------------------------------------------------------
// tb_sha2_msg_schedule
// Self-checking bench for sha2_msg_schedule. Two instances are used: a
// SHA-256 configuration (32-bit, 64 rounds) and a SHA-512 configuration
// (64-bit, 80 rounds). Expected schedule words come from the textbook
// recurrence W_t = s1(W_(t-2)) + W_(t-7) + s0(W_(t-15)) + W_(t-16).
// ---------------------------------------------------------------------------
module tb_sha2_msg_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0;
  logic        start64 = 1'b0;
  logic        abort = 1'b0;
  logic        load_valid = 1'b0;
  logic        w_ready = 1'b0;
  logic [63:0] load_data = 64'd0;

  logic        lr32, wv32, dn32, bz32;
  logic [31:0] wd32;
  logic [6:0]  wi32;
  logic        lr64, wv64, dn64, bz64;
  logic [63:0] wd64;
  logic [6:0]  wi64;

  always #5 clk = ~clk;

  sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .abort(abort),
    .load_valid(load_valid), .load_ready(lr32), .load_data(load_data[31:0]),
    .w_valid(wv32), .w_ready(w_ready), .w_data(wd32), .w_index(wi32),
    .done(dn32), .busy(bz32)
  );

  sha2_msg_schedule #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .abort(abort),
    .load_valid(load_valid), .load_ready(lr64), .load_data(load_data),
    .w_valid(wv64), .w_ready(w_ready), .w_data(wd64), .w_index(wi64),
    .done(dn64), .busy(bz64)
  );

  // Observed outputs of whichever instance the current scenario drives.
  bit          sel_wide = 1'b0;
  logic        obs_lr, obs_wv, obs_dn, obs_bz;
  logic [63:0] obs_wd;
  logic [6:0]  obs_wi;
  always_comb begin
    obs_lr = sel_wide ? lr64 : lr32;
    obs_wv = sel_wide ? wv64 : wv32;
    obs_dn = sel_wide ? dn64 : dn32;
    obs_bz = sel_wide ? bz64 : bz32;
    obs_wd = sel_wide ? wd64 : {32'd0, wd32};
    obs_wi = sel_wide ? wi64 : wi32;
  end

  int checks = 0;
  int errors = 0;

  logic [63:0] cur_msg [16];
  logic [63:0] exp_w [80];
  logic [63:0] cap_data [$];
  int          cap_idx [$];
  logic [63:0] base_data [$];
  int          done_count, done_cyc, stable_viol;
  bit          timed_out, aborted, post_busy, post_done;

  // ---------------- reference model ----------------
  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input bit wide);
    logic [31:0] v;
    if (wide) return (x >> n) | (x << (64 - n));
    v = x[31:0];
    return {32'd0, (v >> n) | (v << (32 - n))};
  endfunction

  function automatic logic [63:0] sg0(input logic [63:0] x, input bit wide);
    if (wide) return rr(x, 1, 1'b1) ^ rr(x, 8, 1'b1) ^ (x >> 7);
    return rr(x, 7, 1'b0) ^ rr(x, 18, 1'b0) ^ ({32'd0, x[31:0]} >> 3);
  endfunction

  function automatic logic [63:0] sg1(input logic [63:0] x, input bit wide);
    if (wide) return rr(x, 19, 1'b1) ^ rr(x, 61, 1'b1) ^ (x >> 6);
    return rr(x, 17, 1'b0) ^ rr(x, 19, 1'b0) ^ ({32'd0, x[31:0]} >> 10);
  endfunction

  task automatic build_model(input bit wide);
    logic [63:0] s;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        s = cur_msg[t];
      end else begin
        s = sg1(exp_w[t-2], wide) + exp_w[t-7] + sg0(exp_w[t-15], wide) + exp_w[t-16];
      end
      if (!wide) s = s & 64'h0000_0000_FFFF_FFFF;
      exp_w[t] = s;
    end
  endtask

  task automatic rand_msg(input bit wide);
    for (int i = 0; i < 16; i++) begin
      cur_msg[i] = wide ? {$urandom, $urandom} : {32'd0, $urandom};
    end
  endtask

  task automatic abc_msg(input bit wide);
    for (int i = 0; i < 16; i++) cur_msg[i] = 64'd0;
    cur_msg[0]  = wide ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
    cur_msg[15] = 64'h0000_0000_0000_0018;
  endtask

  // ---------------- block driver (records, does not judge) ----------------
  // Drives one block: start, load the 16 words of cur_msg, collect accepted
  // words. ld_pct/rdy_pct give the chance per cycle of load_valid/w_ready.
  // abort_at >= 0 aborts when that index is presented. start_noise pulses
  // start while words are streaming and during DONE.
  task automatic run_block(input bit wide, input int ld_pct, input int rdy_pct,
                           input int abort_at, input bit start_noise);
    int          cyc;
    int          ptr;
    bit          fin;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic [6:0]  prev_idx;
    sel_wide = wide;
    cap_data.delete();
    cap_idx.delete();
    done_count = 0; done_cyc = -1; stable_viol = 0;
    timed_out = 1'b0; aborted = 1'b0;
    ptr = 0; fin = 1'b0; prev_stall = 1'b0; prev_data = 64'd0; prev_idx = 7'd0;
    @(negedge clk);
    load_valid = 1'b0; w_ready = 1'b0; abort = 1'b0;
    if (wide) start64 = 1'b1; else start32 = 1'b1;
    cyc = 1;
    while (!fin) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start32 = 1'b0; start64 = 1'b0; abort = 1'b0;
      if (prev_stall) begin
        if (!obs_wv || obs_wd !== prev_data || obs_wi !== prev_idx) stable_viol++;
      end
      if (obs_dn) begin
        done_count++;
        done_cyc = cyc;
        fin = 1'b1;
        load_valid = 1'b0;
        w_ready = 1'b0;
      end else if (cyc > 800) begin
        timed_out = 1'b1;
        fin = 1'b1;
      end else begin
        load_valid = ($urandom_range(99) < ld_pct);
        if (obs_lr && load_valid && ptr < 16) begin
          load_data = cur_msg[ptr];
          ptr++;
        end else begin
          load_data = {$urandom, $urandom};
        end
        w_ready = ($urandom_range(99) < rdy_pct);
        if (obs_wv && abort_at >= 0 && int'(obs_wi) == abort_at) begin
          abort = 1'b1;
          w_ready = 1'b1;
          aborted = 1'b1;
          fin = 1'b1;
        end else if (obs_wv && w_ready) begin
          cap_data.push_back(obs_wd);
          cap_idx.push_back(int'(obs_wi));
        end
        prev_stall = obs_wv && !w_ready;
        prev_data  = obs_wd;
        prev_idx   = obs_wi;
        if (start_noise && obs_wv && $urandom_range(7) == 0) begin
          if (wide) start64 = 1'b1; else start32 = 1'b1;
        end
      end
    end
    // A start during the DONE cycle must be ignored.
    if (start_noise && !aborted && !timed_out) begin
      if (wide) start64 = 1'b1; else start32 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0; start64 = 1'b0; abort = 1'b0;
    load_valid = 1'b0; w_ready = 1'b0;
    post_busy = obs_bz;
    post_done = obs_dn;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (obs_dn) done_count++;
      if (obs_bz) post_busy = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({lr32, wv32, dn32, bz32} !== 4'b0000) begin errors++; $display("FAIL reset_flags32 got %b exp 0000", {lr32, wv32, dn32, bz32}); end
    checks++; if (wd32 !== 32'd0 || wi32 !== 7'd0) begin errors++; $display("FAIL reset_data32 got %h/%0d exp 0/0", wd32, wi32); end
    checks++; if ({lr64, wv64, dn64, bz64} !== 4'b0000) begin errors++; $display("FAIL reset_flags64 got %b exp 0000", {lr64, wv64, dn64, bz64}); end
    checks++; if (wd64 !== 64'd0 || wi64 !== 7'd0) begin errors++; $display("FAIL reset_data64 got %h/%0d exp 0/0", wd64, wi64); end
  endtask

  task automatic test_abc256();
    abc_msg(1'b0);
    build_model(1'b0);
    run_block(1'b0, 100, 100, -1, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL abc256_timeout got timeout exp done"); end
    checks++; if (cap_data.size() != 64) begin errors++; $display("FAIL abc256_count got %0d exp 64", cap_data.size()); end
    for (int t = 0; t < cap_data.size(); t++) begin
      checks++;
      if (cap_data[t] !== exp_w[t] || cap_idx[t] != t) begin
        errors++; $display("FAIL abc256_w%0d got %h@%0d exp %h@%0d", t, cap_data[t], cap_idx[t], exp_w[t], t);
      end
    end
    if (cap_data.size() > 17) begin
      checks++; if (cap_data[0] !== 64'h6162_6380) begin errors++; $display("FAIL abc256_w0 got %h exp 61626380", cap_data[0]); end
      checks++; if (cap_data[16] !== 64'h6162_6380) begin errors++; $display("FAIL abc256_w16 got %h exp 61626380", cap_data[16]); end
      checks++; if (cap_data[17] !== 64'h000F_0000) begin errors++; $display("FAIL abc256_w17 got %h exp 000f0000", cap_data[17]); end
    end
    // Start cycle + 16 load + 64 run + DONE, counted inclusively.
    checks++; if (done_cyc != 82) begin errors++; $display("FAIL abc256_latency got %0d exp 82", done_cyc); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL abc256_done_pulses got %0d exp 1", done_count); end
    checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL abc256_idle got busy=%b exp 0", post_busy); end
  endtask

  task automatic test_abc512();
    abc_msg(1'b1);
    build_model(1'b1);
    run_block(1'b1, 100, 100, -1, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL abc512_timeout got timeout exp done"); end
    checks++; if (cap_data.size() != 80) begin errors++; $display("FAIL abc512_count got %0d exp 80", cap_data.size()); end
    for (int t = 0; t < cap_data.size(); t++) begin
      checks++;
      if (cap_data[t] !== exp_w[t] || cap_idx[t] != t) begin
        errors++; $display("FAIL abc512_w%0d got %h@%0d exp %h@%0d", t, cap_data[t], cap_idx[t], exp_w[t], t);
      end
    end
    if (cap_data.size() == 80) begin
      checks++; if (cap_data[16] !== 64'h6162_6380_0000_0000) begin errors++; $display("FAIL abc512_w16 got %h exp 6162638000000000", cap_data[16]); end
      checks++; if (cap_data[17] !== 64'h0003_0000_0000_00C0) begin errors++; $display("FAIL abc512_w17 got %h exp 00030000000000c0", cap_data[17]); end
      checks++; if (cap_idx[79] != 79) begin errors++; $display("FAIL abc512_last_index got %0d exp 79", cap_idx[79]); end
    end
    checks++; if (done_cyc != 98) begin errors++; $display("FAIL abc512_latency got %0d exp 98", done_cyc); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL abc512_done_pulses got %0d exp 1", done_count); end
  endtask

  task automatic test_backpressure(input bit wide);
    int n;
    n = wide ? 80 : 64;
    rand_msg(wide);
    build_model(wide);
    run_block(wide, 100, 100, -1, 1'b0);
    base_data = cap_data;
    run_block(wide, 55, 45, -1, 1'b0);
    checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout w%0d got timeout exp done", wide); end
    checks++; if (stable_viol != 0) begin errors++; $display("FAIL stall_hold w%0d got %0d changes exp 0", wide, stable_viol); end
    checks++; if (cap_data.size() != n || base_data.size() != n) begin
      errors++; $display("FAIL stall_count w%0d got %0d/%0d exp %0d", wide, cap_data.size(), base_data.size(), n);
    end
    for (int t = 0; t < cap_data.size() && t < base_data.size(); t++) begin
      checks++;
      if (cap_data[t] !== base_data[t] || cap_data[t] !== exp_w[t] || cap_idx[t] != t) begin
        errors++; $display("FAIL stall_w%0d got %h@%0d exp %h", t, cap_data[t], cap_idx[t], exp_w[t]);
      end
    end
    checks++; if (done_count != 1) begin errors++; $display("FAIL stall_done_pulses got %0d exp 1", done_count); end
  endtask

  task automatic test_abort();
    rand_msg(1'b0);
    build_model(1'b0);
    run_block(1'b0, 100, 100, 30, 1'b0);
    checks++; if (!aborted) begin errors++; $display("FAIL abort_reached got 0 exp 1"); end
    checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b exp 0", post_busy); end
    checks++; if (post_done !== 1'b0 || done_count != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_count); end
    checks++; if (cap_data.size() != 30) begin errors++; $display("FAIL abort_prefix got %0d exp 30", cap_data.size()); end
    rand_msg(1'b0);
    build_model(1'b0);
    run_block(1'b0, 100, 100, -1, 1'b0);
    checks++; if (cap_data.size() != 64) begin errors++; $display("FAIL after_abort_count got %0d exp 64", cap_data.size()); end
    for (int t = 0; t < cap_data.size(); t++) begin
      checks++;
      if (cap_data[t] !== exp_w[t] || cap_idx[t] != t) begin
        errors++; $display("FAIL after_abort_w%0d got %h exp %h", t, cap_data[t], exp_w[t]);
      end
    end
  endtask

  task automatic test_rst_mid_load();
    sel_wide = 1'b0;
    @(negedge clk);
    start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load_data = {32'd0, $urandom};
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (lr32 !== 1'b1) begin errors++; $display("FAIL midload_in_load got %b exp 1", lr32); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    load_valid = 1'b0;
    checks++; if ({lr32, wv32, dn32, bz32} !== 4'b0000) begin errors++; $display("FAIL midload_flags got %b exp 0000", {lr32, wv32, dn32, bz32}); end
    checks++; if (wd32 !== 32'd0 || wi32 !== 7'd0) begin errors++; $display("FAIL midload_data got %h/%0d exp 0/0", wd32, wi32); end
    rand_msg(1'b0);
    build_model(1'b0);
    run_block(1'b0, 80, 100, -1, 1'b0);
    checks++; if (cap_data.size() != 64) begin errors++; $display("FAIL midload_reload_count got %0d exp 64", cap_data.size()); end
    for (int t = 0; t < cap_data.size(); t++) begin
      checks++;
      if (cap_data[t] !== exp_w[t]) begin errors++; $display("FAIL midload_reload_w%0d got %h exp %h", t, cap_data[t], exp_w[t]); end
    end
  endtask

  task automatic test_start_noise(input bit wide);
    int n;
    n = wide ? 80 : 64;
    rand_msg(wide);
    build_model(wide);
    run_block(wide, 100, 70, -1, 1'b1);
    checks++; if (cap_data.size() != n) begin errors++; $display("FAIL noise_count w%0d got %0d exp %0d", wide, cap_data.size(), n); end
    for (int t = 0; t < cap_data.size(); t++) begin
      checks++;
      if (cap_data[t] !== exp_w[t] || cap_idx[t] != t) begin
        errors++; $display("FAIL noise_w%0d got %h@%0d exp %h@%0d", t, cap_data[t], cap_idx[t], exp_w[t], t);
      end
    end
    checks++; if (done_count != 1) begin errors++; $display("FAIL noise_done_pulses got %0d exp 1", done_count); end
    checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL noise_idle got busy=%b exp 0", post_busy); end
  endtask

  initial begin
    test_reset();
    test_abc256();
    test_abc512();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_abort();
    test_rst_mid_load();
    test_start_noise(1'b0);
    test_start_noise(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
